// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, memory-busy hold and branch/jump squash,
// sequenced by a four-state FSM with saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int         CNT_W      = 16,
    parameter logic [1:0] LOAD_WBSEL = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1addr,
    input  logic [4:0]       id_rs2addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rdaddr,
    input  logic             ex_regwr,
    input  logic [1:0]       ex_wbsel,
    input  logic             ex_isbr,
    input  logic             ex_brtaken,
    input  logic             ex_willjmp,
    input  logic             mem_busy,
    output logic             stall,
    output logic             pc_hold,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        REPLAY  = 2'd1,
        MEMWAIT = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard, redirect, flush_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign hazard = ex_regwr && (ex_wbsel == LOAD_WBSEL) && (ex_rdaddr != 5'd0) &&
                    ((id_rs1_used && (id_rs1addr == ex_rdaddr)) ||
                     (id_rs2_used && (id_rs2addr == ex_rdaddr)));
    assign redirect = (ex_isbr && ex_brtaken) || ex_willjmp;

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        pc_hold    = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        flush_evt  = 1'b0;
        case (state_q)
            RUN, REPLAY: begin
                if (redirect) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    flush_evt  = 1'b1;
                    state_d    = FLUSH;
                end else if (mem_busy) begin
                    stall   = 1'b1;
                    pc_hold = 1'b1;
                    state_d = MEMWAIT;
                end else if (state_q == REPLAY) begin
                    // Buffered ID instruction drains into EX this cycle.
                    pc_hold = 1'b1;
                    state_d = RUN;
                end else if (hazard) begin
                    stall   = 1'b1;
                    pc_hold = 1'b1;
                    state_d = REPLAY;
                end
            end
            MEMWAIT: begin
                pc_hold = 1'b1;
                if (mem_busy) begin
                    stall = 1'b1;
                end else begin
                    state_d = REPLAY;
                end
            end
            FLUSH: begin
                // Kill the fetch already in flight from synchronous instruction memory.
                flush_ifid = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
        if (!rst) begin
            stall      = 1'b0;
            pc_hold    = 1'b0;
            flush_ifid = 1'b0;
            flush_idex = 1'b0;
            flush_evt  = 1'b0;
            state_d    = RUN;
        end
    end

    assign stall_cnt_d = stall     ? sat_inc(stall_cnt_q) : stall_cnt_q;
    assign flush_cnt_d = flush_evt ? sat_inc(flush_cnt_q) : flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected per-cycle controls are queued as stimulus
// is driven and compared against the DUT at the falling edge.
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1addr, id_rs2addr, ex_rdaddr;
    logic             id_rs1_used, id_rs2_used, ex_regwr;
    logic [1:0]       ex_wbsel;
    logic             ex_isbr, ex_brtaken, ex_willjmp, mem_busy;
    logic             stall, pc_hold, flush_ifid, flush_idex;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    typedef struct packed {
        logic       stall;
        logic       hold;
        logic       fi;
        logic       fx;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .LOAD_WBSEL(2'b01)) dut (
        .clk(clk), .rst(rst),
        .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rdaddr(ex_rdaddr), .ex_regwr(ex_regwr), .ex_wbsel(ex_wbsel),
        .ex_isbr(ex_isbr), .ex_brtaken(ex_brtaken), .ex_willjmp(ex_willjmp),
        .mem_busy(mem_busy),
        .stall(stall), .pc_hold(pc_hold), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .state(state), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, expv);
        end
    endtask

    task automatic idle();
        id_rs1addr = 5'd0; id_rs2addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rdaddr = 5'd0; ex_regwr = 1'b0; ex_wbsel = 2'b00;
        ex_isbr = 1'b0; ex_brtaken = 1'b0; ex_willjmp = 1'b0; mem_busy = 1'b0;
    endtask

    // Load into x5 in EX, ID reads x5 through rs2.
    task automatic load_use();
        idle();
        ex_regwr = 1'b1; ex_wbsel = 2'b01; ex_rdaddr = 5'd5;
        id_rs2addr = 5'd5; id_rs2_used = 1'b1;
    endtask

    // Inputs already applied; queue expectation, compare at negedge, advance past posedge.
    task automatic cyc(input string tag, input logic s, input logic h, input logic fi,
                       input logic fx, input logic [1:0] st);
        exp_t e, got;
        e = '{stall: s, hold: h, fi: fi, fx: fx, st: st};
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check({tag, ".stall"}, 32'(stall), 32'(got.stall));
        check({tag, ".pc_hold"}, 32'(pc_hold), 32'(got.hold));
        check({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(got.fi));
        check({tag, ".flush_idex"}, 32'(flush_idex), 32'(got.fx));
        check({tag, ".state"}, 32'(state), 32'(got.st));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk); #1;
        // Reset: controls forced low even with hazard and busy present
        load_use(); mem_busy = 1'b1; ex_willjmp = 1'b1;
        cyc("rst_hold", 0, 0, 0, 0, 2'd0);
        check("rst_stallcnt", 32'(stall_cycles), 32'd0);
        check("rst_flushcnt", 32'(flush_events), 32'd0);
        rst = 1'b1; idle();

        // Load-use bubble
        load_use(); cyc("lu0", 1, 1, 0, 0, 2'd0);
        idle();     cyc("lu1", 0, 1, 0, 0, 2'd1);
        cyc("lu2", 0, 0, 0, 0, 2'd0);
        check("lu_stallcnt", 32'(stall_cycles), 32'd1);

        // Non-hazards
        load_use(); ex_rdaddr = 5'd0; id_rs2addr = 5'd0; cyc("nh_x0", 0, 0, 0, 0, 2'd0);
        load_use(); id_rs2_used = 1'b0; cyc("nh_unused", 0, 0, 0, 0, 2'd0);
        load_use(); ex_wbsel = 2'b00; cyc("nh_alu", 0, 0, 0, 0, 2'd0);
        load_use(); ex_brtaken = 1'b1; cyc("nh_brnotbr", 1, 1, 0, 0, 2'd0);
        idle(); cyc("nh_brnotbr1", 0, 1, 0, 0, 2'd1);
        load_use(); id_rs2_used = 1'b0; id_rs1_used = 1'b1; id_rs1addr = 5'd5;
        cyc("rs1_hz", 1, 1, 0, 0, 2'd0);
        idle(); cyc("rs1_hz1", 0, 1, 0, 0, 2'd1);
        check("rs1_stallcnt", 32'(stall_cycles), 32'd3);

        // Memory wait of three busy cycles; jump ignored while waiting
        idle(); mem_busy = 1'b1; cyc("mw0", 1, 1, 0, 0, 2'd0);
        ex_willjmp = 1'b1;       cyc("mw1", 1, 1, 0, 0, 2'd2);
        ex_willjmp = 1'b0;       cyc("mw2", 1, 1, 0, 0, 2'd2);
        mem_busy = 1'b0;         cyc("mw3", 0, 1, 0, 0, 2'd2);
        cyc("mw4", 0, 1, 0, 0, 2'd1);
        cyc("mw5", 0, 0, 0, 0, 2'd0);
        check("mw_stallcnt", 32'(stall_cycles), 32'd6);
        check("mw_flushcnt", 32'(flush_events), 32'd0);

        // Taken branch coincident with load-use: redirect wins
        load_use(); ex_isbr = 1'b1; ex_brtaken = 1'b1;
        cyc("br0", 0, 0, 1, 1, 2'd0);
        idle(); cyc("br1", 0, 0, 1, 0, 2'd3);
        cyc("br2", 0, 0, 0, 0, 2'd0);
        check("br_flushcnt", 32'(flush_events), 32'd1);
        check("br_stallcnt", 32'(stall_cycles), 32'd6);

        // Redirect during REPLAY
        load_use(); cyc("rr0", 1, 1, 0, 0, 2'd0);
        idle(); ex_willjmp = 1'b1; cyc("rr1", 0, 0, 1, 1, 2'd1);
        idle(); cyc("rr2", 0, 0, 1, 0, 2'd3);
        cyc("rr3", 0, 0, 0, 0, 2'd0);
        check("rr_flushcnt", 32'(flush_events), 32'd2);

        // mem_busy during REPLAY
        load_use(); cyc("rb0", 1, 1, 0, 0, 2'd0);
        idle(); mem_busy = 1'b1; cyc("rb1", 1, 1, 0, 0, 2'd1);
        mem_busy = 1'b0; cyc("rb2", 0, 1, 0, 0, 2'd2);
        cyc("rb3", 0, 1, 0, 0, 2'd1);
        cyc("rb4", 0, 0, 0, 0, 2'd0);
        check("rb_stallcnt", 32'(stall_cycles), 32'd9);

        // Reset asserted during MEMWAIT
        idle(); mem_busy = 1'b1; cyc("rm0", 1, 1, 0, 0, 2'd0);
        cyc("rm1", 1, 1, 0, 0, 2'd2);
        rst = 1'b0; cyc("rm2", 0, 0, 0, 0, 2'd2);
        rst = 1'b1; idle(); cyc("rm3", 0, 0, 0, 0, 2'd0);
        check("rm_stallcnt", 32'(stall_cycles), 32'd0);
        check("rm_flushcnt", 32'(flush_events), 32'd0);

        // Saturation of stall_cycles
        idle(); mem_busy = 1'b1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        check("sat0", 32'(stall_cycles), 32'hFFFF);
        cyc("sat1", 1, 1, 0, 0, 2'd2);
        check("sat2", 32'(stall_cycles), 32'hFFFF);
        mem_busy = 1'b0;
        cyc("sat3", 0, 1, 0, 0, 2'd2);
        check("sat4", 32'(stall_cycles), 32'hFFFF);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
